// File: rtl/ram2_ctrl_pkg.sv
// Shared definitions for the RAM2 SRAM bus initiator: widths, FSM encoding,
// strobe polarities and the per-state bus level table.
package ram2_ctrl_pkg;

  localparam int CPU_AW = 16;
  localparam int RAM_AW = 18;
  localparam int DW     = 16;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  localparam logic RamChipEnable   = 1'b0;
  localparam logic RamChipDisable  = 1'b1;
  localparam logic RamReadEnable   = 1'b0;
  localparam logic RamReadDisable  = 1'b1;
  localparam logic RamWriteEnable  = 1'b0;
  localparam logic RamWriteDisable = 1'b1;
  localparam logic RamDriveOn      = 1'b1;
  localparam logic RamDriveOff     = 1'b0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    WR3  = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } bus_lvl_t;

  // Bus pin levels held for the whole duration of each state.
  function automatic bus_lvl_t bus_levels(input state_t st);
    bus_lvl_t lvl;
    lvl = '{RamChipDisable, RamReadDisable, RamWriteDisable, RamDriveOff};
    case (st)
      RD1, RD2: lvl = '{RamChipEnable, RamReadEnable, RamWriteDisable, RamDriveOff};
      WR1, WR3: lvl = '{RamChipEnable, RamReadDisable, RamWriteDisable, RamDriveOn};
      WR2:      lvl = '{RamChipEnable, RamReadDisable, RamWriteEnable, RamDriveOn};
      default:  lvl = '{RamChipDisable, RamReadDisable, RamWriteDisable, RamDriveOff};
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// Pipeline-side (IF/MEM) and SRAM-pin signal bundle of the RAM2 initiator.
interface ram2_ctrl_if;
  import ram2_ctrl_pkg::*;

  logic              if_req;
  logic [CPU_AW-1:0] if_addr;
  logic [DW-1:0]     inst_o;
  logic              if_ack;
  logic              if_stall;

  logic              mem_ce;
  logic              mem_re;
  logic              mem_we;
  logic [CPU_AW-1:0] mem_addr;
  logic [DW-1:0]     mem_data_i;
  logic [DW-1:0]     mem_data_o;
  logic              mem_ack;
  logic              mem_stall;

  logic [RAM_AW-1:0] ram2_addr;
  logic [DW-1:0]     ram2_data_o;
  logic              ram2_data_oe;
  logic [DW-1:0]     ram2_data_i;
  logic              ram2_en_n;
  logic              ram2_oe_n;
  logic              ram2_we_n;

  modport slave (
    input  if_req, if_addr, mem_ce, mem_re, mem_we, mem_addr, mem_data_i, ram2_data_i,
    output inst_o, if_ack, if_stall, mem_data_o, mem_ack, mem_stall,
           ram2_addr, ram2_data_o, ram2_data_oe, ram2_en_n, ram2_oe_n, ram2_we_n
  );

  modport master (
    output if_req, if_addr, mem_ce, mem_re, mem_we, mem_addr, mem_data_i, ram2_data_i,
    input  inst_o, if_ack, if_stall, mem_data_o, mem_ack, mem_stall,
           ram2_addr, ram2_data_o, ram2_data_oe, ram2_en_n, ram2_oe_n, ram2_we_n
  );

endinterface

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM bus initiator: arbitrates IF fetches against MEM accesses (MEM wins)
// and sequences the SRAM strobes; every bus pin and ack comes from a register.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ram2_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  src_t              src_q, src_d;
  bus_lvl_t          lvl_q, lvl_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     inst_q, inst_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              mem_req_s;

  assign mem_req_s = bus.mem_ce && (bus.mem_re || bus.mem_we);

  // Next state, latched transaction fields and registered output values.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    inst_d  = inst_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req_s) begin
          src_d   = SRC_MEM;
          addr_d  = {{(RAM_AW-CPU_AW){1'b0}}, bus.mem_addr};
          wdata_d = bus.mem_data_i;
          if (bus.mem_we) begin
            state_d = WR1;
          end else begin
            state_d = RD1;
          end
        end else if (bus.if_req) begin
          src_d   = SRC_IF;
          addr_d  = {{(RAM_AW-CPU_AW){1'b0}}, bus.if_addr};
          wdata_d = bus.mem_data_i;
          state_d = RD1;
        end else begin
          state_d = IDLE;
        end
      end
      RD1: state_d = RD2;
      RD2: begin
        state_d = DONE;
        // Only the register belonging to the latched requester is updated.
        if (src_q == SRC_IF) begin
          inst_d = bus.ram2_data_i;
        end else begin
          rdata_d = bus.ram2_data_i;
        end
      end
      WR1:     state_d = WR2;
      WR2:     state_d = WR3;
      WR3:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    lvl_d     = bus_levels(state_d);
    if_ack_d  = (state_d == DONE) && (src_d == SRC_IF);
    mem_ack_d = (state_d == DONE) && (src_d == SRC_MEM);
  end

  // State and output registers; reset returns the bus to idle levels at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= SRC_IF;
      lvl_q     <= '{RamChipDisable, RamReadDisable, RamWriteDisable, RamDriveOff};
      addr_q    <= {RAM_AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      inst_q    <= NOP_WORD;
      rdata_q   <= {DW{1'b0}};
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      lvl_q     <= lvl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
      if_ack_q  <= if_ack_d;
      mem_ack_q <= mem_ack_d;
    end
  end

  assign bus.ram2_addr    = addr_q;
  assign bus.ram2_data_o  = wdata_q;
  assign bus.ram2_data_oe = lvl_q.data_oe;
  assign bus.ram2_en_n    = lvl_q.en_n;
  assign bus.ram2_oe_n    = lvl_q.oe_n;
  assign bus.ram2_we_n    = lvl_q.we_n;
  assign bus.inst_o       = inst_q;
  assign bus.mem_data_o   = rdata_q;
  assign bus.if_ack       = if_ack_q;
  assign bus.mem_ack      = mem_ack_q;
  assign bus.if_stall     = bus.if_req && !if_ack_q;
  assign bus.mem_stall    = mem_req_s && !mem_ack_q;

endmodule
